// File: rtl/np_mm_frame_buffer_if.sv
// Producer/consumer bundle for np_mm_frame_buffer: pixel write stream plus bank/word read select.
interface np_mm_frame_buffer_if #(
  parameter int NUM_BUF = 4,
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 8
);
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_ready;
  logic [NUM_BUF-1:0] reading_frame;
  logic [ADDR_W-1:0]  buf_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [NUM_BUF-1:0] frame_rdy;
  logic               underrun;

  modport master (
    output wr_en, wr_data, reading_frame, buf_addr,
    input  wr_ready, rd_data, frame_rdy, underrun
  );

  modport slave (
    input  wr_en, wr_data, reading_frame, buf_addr,
    output wr_ready, rd_data, frame_rdy, underrun
  );
endinterface

// File: rtl/np_mm_frame_buffer.sv
// Rotating multi-bank pixel frame buffer feeding the FFN MAC stage; NP_MM_BUF_UNDERRUN_CNT_EN adds debug counters.
// Read latency 1 cycle (registered rd_data/underrun); writes take effect on the accepting edge.
// Backpressure: wr_ready drops while the target bank still holds an unconsumed frame.
module np_mm_frame_buffer #(
  parameter int NUM_BUF = 4,
  parameter int DATA_W  = 9,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic clock,
  input  logic reset,
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
  output logic [15:0] frames_written,
`endif
  np_mm_frame_buffer_if.slave bus
);

  localparam int               BANK_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [NUM_BUF][DEPTH];
  logic [ADDR_W-1:0]  wr_addr;
  logic [NUM_BUF-1:0] wr_bank;
  logic [NUM_BUF-1:0] frame_rdy;
  logic [NUM_BUF-1:0] prev_frame;
  logic [DATA_W-1:0]  rd_data;
  logic               underrun;

  logic               wr_ready;
  logic               wr_fire;
  logic               fill_done;
  logic [BANK_W-1:0]  wr_idx;
  logic [BANK_W-1:0]  rd_idx;
  logic               rd_ok;
  logic [NUM_BUF-1:0] set_mask;
  logic [NUM_BUF-1:0] rel_mask;
  logic [NUM_BUF-1:0] frame_rdy_nxt;

  function automatic logic [BANK_W-1:0] low_idx(input logic [NUM_BUF-1:0] v);
    low_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (v[i]) low_idx = BANK_W'(i);
    end
  endfunction

  assign wr_ready  = ~|(frame_rdy & wr_bank);
  assign wr_fire   = bus.wr_en & wr_ready;
  assign fill_done = wr_fire & (wr_addr == LAST);
  assign wr_idx    = low_idx(wr_bank);
  assign rd_idx    = low_idx(bus.reading_frame);
  assign rd_ok     = (|bus.reading_frame) & frame_rdy[rd_idx];

  // A change of reading_frame means the consumer is done with the bank it was on.
  assign rel_mask = ((bus.reading_frame != prev_frame) && (|prev_frame))
                  ? (NUM_BUF'(1) << low_idx(prev_frame)) : '0;
  assign set_mask = fill_done ? wr_bank : '0;
  // Set is applied after clear so a forced same-bank collision leaves the bank full.
  assign frame_rdy_nxt = (frame_rdy & ~rel_mask) | set_mask;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_addr    <= '0;
      wr_bank    <= NUM_BUF'(1);
      frame_rdy  <= '0;
      prev_frame <= NUM_BUF'(1);
      rd_data    <= '0;
      underrun   <= 1'b0;
    end else begin
      prev_frame <= bus.reading_frame;
      frame_rdy  <= frame_rdy_nxt;
      if (wr_fire) begin
        if (fill_done) begin
          wr_addr <= '0;
          wr_bank <= {wr_bank[NUM_BUF-2:0], wr_bank[NUM_BUF-1]};
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
      rd_data  <= rd_ok ? mem[rd_idx][bus.buf_addr] : '0;
      underrun <= ~rd_ok;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (reset && wr_fire) begin
      mem[wr_idx][wr_addr] <= bus.wr_data;
    end
  end

`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      underrun_cnt   <= '0;
      frames_written <= '0;
    end else begin
      if (!rd_ok && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      if (fill_done) frames_written <= frames_written + 16'd1;
    end
  end
`endif

  assign bus.wr_ready  = wr_ready;
  assign bus.rd_data   = rd_data;
  assign bus.frame_rdy = frame_rdy;
  assign bus.underrun  = underrun;

endmodule

// File: tb/tb_np_mm_frame_buffer.sv
// Directed bench for np_mm_frame_buffer: stimulus pushes expectations, a monitor checks them one edge later.
module tb_np_mm_frame_buffer;

  localparam int W_RD_DATA  = 0;
  localparam int W_UNDERRUN = 1;
  localparam int W_FRAME    = 2;
  localparam int W_WR_READY = 3;
  localparam int W_WR_BANK  = 4;
  localparam int W_WR_ADDR  = 5;
  localparam int W_MEM00    = 6;
  localparam int W_UCNT     = 7;
  localparam int W_FWR      = 8;

  typedef struct {
    int          which;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t item;
  logic [31:0] act;

`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
  logic [15:0] frames_written;
`endif

  np_mm_frame_buffer_if #(.NUM_BUF(4), .DATA_W(9), .ADDR_W(8)) bus ();

  np_mm_frame_buffer #(.NUM_BUF(4), .DATA_W(9), .DEPTH(256), .ADDR_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
    .underrun_cnt   (underrun_cnt),
    .frames_written (frames_written),
`endif
    .bus            (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] sample(input int which);
    case (which)
      W_RD_DATA:  sample = 32'(bus.rd_data);
      W_UNDERRUN: sample = 32'(bus.underrun);
      W_FRAME:    sample = 32'(bus.frame_rdy);
      W_WR_READY: sample = 32'(bus.wr_ready);
      W_WR_BANK:  sample = 32'(dut.wr_bank);
      W_WR_ADDR:  sample = 32'(dut.wr_addr);
      W_MEM00:    sample = 32'(dut.mem[0][0]);
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
      W_UCNT:     sample = 32'(underrun_cnt);
      W_FWR:      sample = 32'(frames_written);
`endif
      default:    sample = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input int which, input logic [31:0] v, input string nm);
    exp_t e;
    e.which = which;
    e.exp   = v;
    e.nm    = nm;
    exp_q.push_back(e);
  endtask

  // Expectations queued at a falling edge are due right after the next rising edge.
  always @(posedge clock) begin
    if (exp_q.size() > 0) begin
      #1;
      while (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        act  = sample(item.which);
        checks++;
        if (act !== item.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", item.nm, act, item.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic write_word(input logic [8:0] d);
    for (int k = 0; k < 50 && !bus.wr_ready; k++) @(negedge clock);
    if (!bus.wr_ready) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_wait: got 0 expected 1 within 50 cycles at %0t", $time);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic fill(input int n, input logic [8:0] base, input logic [8:0] dir);
    for (int i = 0; i < n; i++) begin
      write_word(base + dir * 9'(i));
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b0;
    bus.wr_en         = 1'b0;
    bus.wr_data       = '0;
    bus.reading_frame = 4'b0001;
    bus.buf_addr      = '0;

    @(negedge clock);
    expect_val(W_FRAME,    32'h0, "reset_frame_rdy");
    expect_val(W_WR_READY, 32'h1, "reset_wr_ready");
    expect_val(W_RD_DATA,  32'h0, "reset_rd_data");
    expect_val(W_UNDERRUN, 32'h0, "reset_underrun");
    expect_val(W_WR_BANK,  32'h1, "reset_wr_bank");
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
    expect_val(W_UCNT,     32'h0, "reset_underrun_cnt");
`endif
    tick();

    // Empty buffer read of bank0 addr0.
    reset = 1'b1;
    expect_val(W_RD_DATA,  32'h0, "empty_rd_data");
    expect_val(W_UNDERRUN, 32'h1, "empty_underrun");
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
    expect_val(W_UCNT,     32'h1, "empty_underrun_cnt");
`endif
    tick();

    // Bank0 gets 0..255.
    fill(255, 9'h000, 9'h001);
    write_word(9'd255);
    expect_val(W_FRAME,    32'h1, "fill0_frame_rdy");
    expect_val(W_WR_READY, 32'h1, "fill0_wr_ready");
    expect_val(W_WR_BANK,  32'h2, "fill0_wr_bank");
    expect_val(W_WR_ADDR,  32'h0, "fill0_wr_addr");
`ifdef NP_MM_BUF_UNDERRUN_CNT_EN
    expect_val(W_FWR,      32'h1, "fill0_frames_written");
`endif
    tick();

    bus.buf_addr = 8'd5;
    expect_val(W_RD_DATA,  32'd5, "rd_b0_a5");
    expect_val(W_UNDERRUN, 32'h0, "rd_b0_a5_underrun");
    tick();
    bus.buf_addr = 8'd255;
    expect_val(W_RD_DATA,  32'd255, "rd_b0_a255");
    expect_val(W_UNDERRUN, 32'h0,   "rd_b0_a255_underrun");
    tick();

    // Banks 1..3: bank1 = 0x100+i, bank2 = i, bank3 = 0x100+i.
    fill(256, 9'h100, 9'h001);
    fill(256, 9'h000, 9'h001);
    fill(255, 9'h100, 9'h001);
    write_word(9'h1FF);
    expect_val(W_FRAME,    32'hF, "full_frame_rdy");
    expect_val(W_WR_READY, 32'h0, "full_wr_ready");
    expect_val(W_WR_BANK,  32'h1, "full_wr_bank");
    tick();

    bus.wr_en   = 1'b1;
    bus.wr_data = 9'h055;
    expect_val(W_FRAME,   32'hF, "blocked_frame_rdy");
    expect_val(W_WR_ADDR, 32'h0, "blocked_wr_addr");
    expect_val(W_WR_BANK, 32'h1, "blocked_wr_bank");
    tick();

    // Consumer moves to bank1: bank0 released, read from bank1 the same cycle.
    bus.reading_frame = 4'b0010;
    bus.buf_addr      = 8'd7;
    expect_val(W_FRAME,    32'hE,   "release0_frame_rdy");
    expect_val(W_WR_READY, 32'h1,   "release0_wr_ready");
    expect_val(W_RD_DATA,  32'h107, "rd_b1_a7");
    expect_val(W_UNDERRUN, 32'h0,   "rd_b1_a7_underrun");
    tick();

    write_word(9'h1AA);
    expect_val(W_WR_ADDR, 32'h1,   "refill_wr_addr");
    expect_val(W_WR_BANK, 32'h1,   "refill_wr_bank");
    expect_val(W_MEM00,   32'h1AA, "refill_mem_b0_a0");
    expect_val(W_FRAME,   32'hE,   "refill_frame_rdy");
    tick();

    bus.reading_frame = 4'b0100;
    bus.buf_addr      = 8'd3;
    expect_val(W_FRAME,    32'hC, "release1_frame_rdy");
    expect_val(W_RD_DATA,  32'd3, "rd_b2_a3");
    expect_val(W_UNDERRUN, 32'h0, "rd_b2_a3_underrun");
    tick();

    // Reset mid-frame discards a 100-word partial frame.
    bus.reading_frame = 4'b0001;
    bus.buf_addr      = 8'd0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    fill(100, 9'h000, 9'h001);
    reset = 1'b0;
    expect_val(W_FRAME,    32'h0, "midrst_frame_rdy");
    expect_val(W_WR_ADDR,  32'h0, "midrst_wr_addr");
    expect_val(W_WR_BANK,  32'h1, "midrst_wr_bank");
    expect_val(W_RD_DATA,  32'h0, "midrst_rd_data");
    expect_val(W_UNDERRUN, 32'h0, "midrst_underrun");
    tick();
    reset = 1'b1;
    fill(255, 9'h0FF, 9'h1FF);
    write_word(9'h000);
    expect_val(W_FRAME,   32'h1, "midrst_fill_frame_rdy");
    expect_val(W_WR_BANK, 32'h2, "midrst_fill_wr_bank");
    tick();
    bus.buf_addr = 8'd50;
    expect_val(W_RD_DATA, 32'd205, "midrst_rd_a50");
    tick();
    bus.buf_addr = 8'd99;
    expect_val(W_RD_DATA, 32'd156, "midrst_rd_a99");
    tick();

    // Bank3 completes in the same cycle the consumer leaves bank0.
    fill(256, 9'h000, 9'h001);
    fill(256, 9'h000, 9'h001);
    fill(254, 9'h000, 9'h001);
    write_word(9'd254);
    expect_val(W_FRAME, 32'h7, "simul_pre_frame_rdy");
    tick();
    write_word(9'd255);
    bus.reading_frame = 4'b0010;
    expect_val(W_FRAME,    32'hE, "simul_frame_rdy");
    expect_val(W_WR_BANK,  32'h1, "simul_wr_bank");
    expect_val(W_WR_READY, 32'h1, "simul_wr_ready");
    tick();

    tick();
    tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
